// File: rtl/vram_arbiter_if.sv
// Handshake/bus bundle between the VGA fetch path, two writers, the arbiter and the character RAM.
interface vram_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
);
    logic              video_on;
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_valid;
    logic [DATA_W-1:0] fetch_data;
    logic              wr0_req,  wr1_req;
    logic [ADDR_W-1:0] wr0_addr, wr1_addr;
    logic [DATA_W-1:0] wr0_data, wr1_data;
    logic              wr0_ack,  wr1_ack;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        input  video_on, fetch_req, fetch_addr,
        input  wr0_req, wr1_req, wr0_addr, wr1_addr, wr0_data, wr1_data,
        input  ram_rdata,
        output fetch_valid, fetch_data, wr0_ack, wr1_ack,
        output ram_en, ram_we, ram_addr, ram_wdata
    );

    modport master (
        output video_on, fetch_req, fetch_addr,
        output wr0_req, wr1_req, wr0_addr, wr1_addr, wr0_data, wr1_data,
        output ram_rdata,
        input  fetch_valid, fetch_data, wr0_ack, wr1_ack,
        input  ram_en, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/vram_arbiter.sv
// Character-RAM arbiter: display fetch has absolute priority, two writers share idle cycles round-robin.
// Define VRAM_BLANK_WRITE_EN to restrict writes to blanking (video_on=0) cycles.
module vram_arbiter #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 8,
    parameter int STALL_W = 16
) (
    input  logic               clk_i,
    input  logic               reset_i,
    vram_arbiter_if.slave      bus,
    output logic [STALL_W-1:0] stall_cnt_o
);
    logic               ram_en_q,    ram_en_d;
    logic               ram_we_q,    ram_we_d;
    logic [ADDR_W-1:0]  ram_addr_q,  ram_addr_d;
    logic [DATA_W-1:0]  ram_wdata_q, ram_wdata_d;
    logic               ack0_q,      ack0_d;
    logic               ack1_q,      ack1_d;
    logic               last_wr_q,   last_wr_d;
    logic [1:0]         vld_pipe_q,  vld_pipe_d;
    logic [STALL_W-1:0] stall_q,     stall_d;

    logic raw0, raw1, elig0, elig1, blk, sel1, grant_wr, stall_inc;

    // A writer whose ack is showing this cycle is masked so it is not served twice.
    assign raw0 = bus.wr0_req & ~ack0_q;
    assign raw1 = bus.wr1_req & ~ack1_q;

`ifdef VRAM_BLANK_WRITE_EN
    assign elig0 = raw0 & ~bus.video_on;
    assign elig1 = raw1 & ~bus.video_on;
    assign blk   = bus.video_on & (raw0 | raw1);
`else
    logic unused_video_on;
    assign unused_video_on = bus.video_on;
    assign elig0 = raw0;
    assign elig1 = raw1;
    assign blk   = 1'b0;
`endif

    always_comb begin
        sel1        = (elig0 & elig1) ? ~last_wr_q : elig1;
        grant_wr    = ~bus.fetch_req & (elig0 | elig1);
        stall_inc   = (bus.fetch_req & (elig0 | elig1)) | blk;

        ram_en_d    = bus.fetch_req | grant_wr;
        ram_we_d    = grant_wr;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        if (bus.fetch_req) begin
            ram_addr_d = bus.fetch_addr;
        end else if (grant_wr) begin
            ram_addr_d  = sel1 ? bus.wr1_addr : bus.wr0_addr;
            ram_wdata_d = sel1 ? bus.wr1_data : bus.wr0_data;
        end

        ack0_d     = grant_wr & ~sel1;
        ack1_d     = grant_wr &  sel1;
        last_wr_d  = grant_wr ? sel1 : last_wr_q;
        vld_pipe_d = {vld_pipe_q[0], bus.fetch_req};

        stall_d = stall_q;
        if (stall_inc && (stall_q != {STALL_W{1'b1}}))
            stall_d = stall_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            last_wr_q   <= 1'b1;  // wr0 wins the first tie
            vld_pipe_q  <= '0;
            stall_q     <= '0;
        end else begin
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ack0_q      <= ack0_d;
            ack1_q      <= ack1_d;
            last_wr_q   <= last_wr_d;
            vld_pipe_q  <= vld_pipe_d;
            stall_q     <= stall_d;
        end
    end

    assign bus.ram_en      = ram_en_q;
    assign bus.ram_we      = ram_we_q;
    assign bus.ram_addr    = ram_addr_q;
    assign bus.ram_wdata   = ram_wdata_q;
    assign bus.wr0_ack     = ack0_q;
    assign bus.wr1_ack     = ack1_q;
    assign bus.fetch_valid = vld_pipe_q[1];
    assign bus.fetch_data  = bus.ram_rdata;
    assign stall_cnt_o     = stall_q;
endmodule
